// File: rtl/prog_timer_counter.sv
// prog_timer_counter: free-running modulo up counter plus FSM-driven down counter
// with one-shot/auto-reload modes, abort and terminal-count pulses.
module prog_timer_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             areset_n,
   input  logic             enable,
   input  logic             up_clear,
   input  logic [WIDTH-1:0] up_max,
   input  logic             down_start,
   input  logic [WIDTH-1:0] down_load,
   input  logic             auto_reload,
   input  logic             down_abort,
   output logic [WIDTH-1:0] out_count_up,
   output logic [WIDTH-1:0] out_count_down,
   output logic             up_wrap,
   output logic             down_done,
   output logic             down_busy
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;
   logic [0:0]       state;
   logic [WIDTH-1:0] rld;
   logic             ar;
   assign down_busy = (state == RUN);
   // >= rather than == so lowering up_max below the current count still wraps
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         out_count_up <= '0;
         up_wrap      <= 1'b0;
      end else if (up_clear) begin
         out_count_up <= '0;
         up_wrap      <= 1'b0;
      end else if (enable && out_count_up >= up_max) begin
         out_count_up <= '0;
         up_wrap      <= 1'b1;
      end else begin
         out_count_up <= enable ? out_count_up + 1'b1 : out_count_up;
         up_wrap      <= 1'b0;
      end
   end
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state          <= IDLE;
         out_count_down <= '0;
         down_done      <= 1'b0;
         rld            <= '0;
         ar             <= 1'b0;
      end else begin
         down_done <= 1'b0;
         if (down_abort) begin
            state          <= IDLE;
            out_count_down <= '0;
         end else if (down_start && down_load != '0) begin
            state          <= RUN;
            out_count_down <= down_load;
            rld            <= down_load;
            ar             <= auto_reload;
         end else if (down_start) begin
            state          <= IDLE;
            out_count_down <= '0;
            down_done      <= 1'b1;
         end else if (state == RUN && enable) begin
            if (out_count_down > WIDTH'(1)) begin
               out_count_down <= out_count_down - 1'b1;
            end else begin
               down_done      <= 1'b1;
               out_count_down <= ar ? rld : '0;
               state          <= ar ? RUN : IDLE;
            end
         end
      end
   end
endmodule

// File: tb/tb_prog_timer_counter.sv
// tb_prog_timer_counter: directed stimulus, per-cycle comparison against an
// integer behavioural model, plus literal spot checks at key points.
module tb_prog_timer_counter;
   logic       clk = 1'b0;
   logic       areset_n = 1'b0;
   logic       enable = 1'b0;
   logic       up_clear = 1'b0;
   logic [7:0] up_max = 8'd9;
   logic [3:0] up_max4 = 4'd15;
   logic       down_start = 1'b0;
   logic [7:0] down_load = 8'd0;
   logic       auto_reload = 1'b0;
   logic       down_abort = 1'b0;
   logic [7:0] out_count_up, out_count_down;
   logic       up_wrap, down_done, down_busy;
   logic [3:0] up4, dn4;
   logic       wrap4, done4, busy4;
   int checks = 0;
   int failures = 0;
   int m_up = 0, m_dn = 0, m_rld = 0, m_up4 = 0;
   bit m_wrap = 0, m_done = 0, m_busy = 0, m_ar = 0, m_wrap4 = 0;

   prog_timer_counter #(.WIDTH(8)) dut (
      .clk(clk), .areset_n(areset_n), .enable(enable), .up_clear(up_clear),
      .up_max(up_max), .down_start(down_start), .down_load(down_load),
      .auto_reload(auto_reload), .down_abort(down_abort),
      .out_count_up(out_count_up), .out_count_down(out_count_down),
      .up_wrap(up_wrap), .down_done(down_done), .down_busy(down_busy)
   );

   prog_timer_counter #(.WIDTH(4)) dut4 (
      .clk(clk), .areset_n(areset_n), .enable(enable), .up_clear(up_clear),
      .up_max(up_max4), .down_start(down_start), .down_load(down_load[3:0]),
      .auto_reload(auto_reload), .down_abort(down_abort),
      .out_count_up(up4), .out_count_down(dn4),
      .up_wrap(wrap4), .down_done(done4), .down_busy(busy4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge areset_n) begin
      m_up = 0; m_wrap = 0; m_dn = 0; m_done = 0; m_busy = 0; m_rld = 0; m_ar = 0;
      m_up4 = 0; m_wrap4 = 0;
   end

   // Model: the up counter is a residue that resets past up_max; the down side
   // tracks "remaining ticks" and whether a timer is armed.
   always @(posedge clk) begin
      if (areset_n) begin
         if (up_clear) begin
            m_up = 0; m_wrap = 0; m_up4 = 0; m_wrap4 = 0;
         end else begin
            m_wrap  = enable && m_up >= int'(up_max);
            m_up    = m_wrap ? 0 : (enable ? (m_up + 1) % 256 : m_up);
            m_wrap4 = enable && m_up4 >= int'(up_max4);
            m_up4   = m_wrap4 ? 0 : (enable ? (m_up4 + 1) % 16 : m_up4);
         end
         m_done = 0;
         if (down_abort) begin
            m_dn = 0; m_busy = 0;
         end else if (down_start) begin
            m_done = (down_load == 0);
            m_busy = (down_load != 0);
            m_dn   = int'(down_load);
            if (down_load != 0) begin
               m_rld = int'(down_load); m_ar = auto_reload;
            end
         end else if (m_busy && enable) begin
            m_dn = m_dn - 1;
            if (m_dn == 0) begin
               m_done = 1;
               m_dn   = m_ar ? m_rld : 0;
               m_busy = m_ar;
            end
         end
      end
   end

   always @(posedge clk) begin
      #2;
      if (areset_n) begin
         chk("m_up", int'(out_count_up), m_up);
         chk("m_wrap", int'(up_wrap), int'(m_wrap));
         chk("m_dn", int'(out_count_down), m_dn);
         chk("m_done", int'(down_done), int'(m_done));
         chk("m_busy", int'(down_busy), int'(m_busy));
         chk("m_up4", int'(up4), m_up4);
         chk("m_wrap4", int'(wrap4), int'(m_wrap4));
      end
   end

   initial begin
      #1;
      chk("rst_up", int'(out_count_up), 0);
      chk("rst_dn", int'(out_count_down), 0);
      chk("rst_busy", int'(down_busy), 0);
      @(negedge clk);
      areset_n = 1'b1; enable = 1'b1;
      step(6);
      chk("up_at6", int'(out_count_up), 6);
      #2 areset_n = 1'b0;
      #1;
      chk("arst_up", int'(out_count_up), 0);
      chk("arst_wrap", int'(up_wrap), 0);
      chk("arst_dn", int'(out_count_down), 0);
      chk("arst_done", int'(down_done), 0);
      chk("arst_busy", int'(down_busy), 0);
      @(negedge clk) areset_n = 1'b1;
      step(9);
      chk("up_at9", int'(out_count_up), 9);
      step(1);
      chk("up_wrap0", int'(out_count_up), 0);
      chk("up_wrap_pulse", int'(up_wrap), 1);
      // one-shot
      down_load = 8'd10; auto_reload = 1'b0; down_start = 1'b1;
      step(1); down_start = 1'b0;
      chk("os_load", int'(out_count_down), 10);
      chk("os_busy", int'(down_busy), 1);
      step(9);
      chk("os_at1", int'(out_count_down), 1);
      step(1);
      chk("os_end", int'(out_count_down), 0);
      chk("os_done", int'(down_done), 1);
      chk("os_idle", int'(down_busy), 0);
      step(1);
      chk("os_done_off", int'(down_done), 0);
      // auto-reload then abort
      down_load = 8'd3; auto_reload = 1'b1; down_start = 1'b1;
      step(1); down_start = 1'b0; auto_reload = 1'b0; down_load = 8'd50;
      step(2);
      chk("ar_at1", int'(out_count_down), 1);
      step(1);
      chk("ar_reload", int'(out_count_down), 3);
      chk("ar_done", int'(down_done), 1);
      step(1);
      chk("ar_at2", int'(out_count_down), 2);
      down_abort = 1'b1;
      step(1); down_abort = 1'b0;
      chk("ab_dn", int'(out_count_down), 0);
      chk("ab_busy", int'(down_busy), 0);
      chk("ab_done", int'(down_done), 0);
      // enable gating, restart, start+abort
      enable = 1'b0; down_load = 8'd5; down_start = 1'b1;
      step(1); down_start = 1'b0;
      chk("en0_load", int'(out_count_down), 5);
      step(4);
      chk("en0_hold", int'(out_count_down), 5);
      chk("en0_busy", int'(down_busy), 1);
      enable = 1'b1;
      step(3);
      chk("en1_at2", int'(out_count_down), 2);
      down_load = 8'd7; down_start = 1'b1;
      step(1); down_start = 1'b0;
      chk("restart", int'(out_count_down), 7);
      chk("restart_done", int'(down_done), 0);
      down_start = 1'b1; down_abort = 1'b1;
      step(1); down_start = 1'b0; down_abort = 1'b0;
      chk("sa_dn", int'(out_count_down), 0);
      chk("sa_busy", int'(down_busy), 0);
      // up_max lowered, clear, up_max=0
      up_clear = 1'b1;
      step(1); up_clear = 1'b0;
      step(7);
      chk("up_at7", int'(out_count_up), 7);
      up_max = 8'd4;
      step(1);
      chk("lower_up", int'(out_count_up), 0);
      chk("lower_wrap", int'(up_wrap), 1);
      step(3);
      up_clear = 1'b1;
      step(1); up_clear = 1'b0;
      chk("clr_up", int'(out_count_up), 0);
      chk("clr_wrap", int'(up_wrap), 0);
      up_max = 8'd0;
      step(3);
      chk("max0_up", int'(out_count_up), 0);
      chk("max0_wrap", int'(up_wrap), 1);
      // zero load
      down_load = 8'd0; down_start = 1'b1;
      step(1); down_start = 1'b0;
      chk("z_done", int'(down_done), 1);
      chk("z_busy", int'(down_busy), 0);
      step(1);
      chk("z_done_off", int'(down_done), 0);
      // 4-bit full-range wrap
      up_clear = 1'b1;
      step(1); up_clear = 1'b0;
      step(15);
      chk("w4_at15", int'(up4), 15);
      step(1);
      chk("w4_wrap", int'(up4), 0);
      chk("w4_pulse", int'(wrap4), 1);
      step(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/prog_timer_counter.md
Name: prog_timer_counter

Overview:
Parametrised successor to the fixed 4-bit up/down counter pair. It contains a free-running up counter with a runtime-programmable modulo. It also contains a down counter controlled by a small FSM, with one-shot and auto-reload modes, abort, and terminal-count pulses. The block serves as the general timer/tick source for control logic in this design level.

Parameters:
WIDTH, 8, bit width of both counters, all count/load inputs and count outputs (WIDTH >= 2)

Ports:
clk  input  1  rising-edge clock
areset_n  input  1  asynchronous active-low reset
enable  input  1  count-step enable for both counters; start, load, clear and abort are accepted regardless of enable
up_clear  input  1  synchronous clear of the up counter
up_max  input  WIDTH  terminal value of the up counter; sequence is 0..up_max
down_start  input  1  load down_load into the down counter and start or restart it
down_load  input  WIDTH  start/reload value, sampled only on down_start
auto_reload  input  1  mode select, sampled only on down_start; 1 selects periodic mode
down_abort  input  1  stop the down counter and force it to 0
out_count_up  output  WIDTH  up counter value
out_count_down  output  WIDTH  down counter value
up_wrap  output  1  one-cycle pulse, high in the cycle out_count_up returns to 0 by wrapping
down_done  output  1  one-cycle pulse on down-count terminal event
down_busy  output  1  high while the down FSM is in RUN

Behaviour:
- Reset: areset_n low immediately forces all of the following, with no clock edge required:
  - all outputs to 0
  - FSM to IDLE
  - latched reload value and mode to 0
- Reset is released synchronously by the integrating logic. The first counting edge follows release.
- All outputs are registered. Nothing is combinational from inputs to outputs.

Up counter, evaluated at each rising edge in priority order:
1. up_clear=1: count <= 0, up_wrap <= 0. Clear is not a wrap.
2. enable=1 and count >= up_max: count <= 0, up_wrap <= 1. The >= handles up_max being lowered below the current count. up_max=0 gives count fixed at 0 with up_wrap high on every enabled cycle.
3. enable=1: count <= count+1, up_wrap <= 0.
4. Otherwise: hold count, up_wrap <= 0.

Down FSM:
- States are IDLE and RUN. down_busy = (state==RUN).
- Latched registers: rld (WIDTH) and ar (1 bit), both captured on an accepted down_start.
- Priority in both states: down_abort > down_start > decrement.
- down_abort: state <= IDLE, count <= 0, down_done <= 0. This is silent, with no done pulse.
- down_start with down_load != 0:
  - count <= down_load, rld <= down_load, ar <= auto_reload, state <= RUN.
  - In RUN this is a restart with no done pulse.
  - The load is accepted even when enable=0.
- down_start with down_load == 0: count <= 0, state <= IDLE, down_done <= 1 for one cycle.
- RUN, enable=1, count > 1: count <= count-1.
- RUN, enable=1, count == 1: down_done <= 1, then:
  - ar=1: count <= rld, stay in RUN. Period = rld enabled cycles; 0 is never displayed.
  - ar=0: count <= 0, state <= IDLE.
- RUN, enable=0: hold.
- IDLE with no start: count holds at 0.
- down_done is 0 in every cycle not listed above.
- Changes to down_load or auto_reload outside a down_start have no effect.

Width/arithmetic:
- All counting is modulo 2^WIDTH.
- Up count never exceeds max(up_max, prior count).
- The down counter never underflows, because the decrement is gated by count > 0 via FSM state.

Test Plan:
1. WIDTH=8, up_max=9, enable=1 after reset -> out_count_up 0,1..9,0,1..; up_wrap high only in cycles showing 0 after 9 (period 10); areset_n pulsed low mid-sequence at count 6 -> count 0 and all outputs 0 before the next clk edge.
2. down_load=10, auto_reload=0, down_start for 1 cycle -> out_count_down 10,9..1,0 on successive edges; down_busy high from 10 through 1; down_done high exactly with the 0 cycle; stays 0/IDLE afterwards.
3. down_load=3, auto_reload=1, start -> sequence 3,2,1,3,2,1,...; down_done high on each 1->3 transition; down_abort at count 2 -> count 0, busy 0, no done pulse.
4. enable=0: both counts hold for 5 cycles; down_start with load 5 during enable=0 -> count 5 held, busy 1; re-enable -> 4,3..; down_start with load 7 at count 2 -> restart at 7, no done; start and abort in the same cycle -> IDLE, count 0.
5. Up count at 7, up_max changed to 4 -> next enabled edge count 0 with up_wrap=1; up_clear with enable=1 at count 3 -> 0 with up_wrap=0; up_max=0 -> count stays 0, up_wrap high every enabled cycle.
6. down_start with down_load=0 -> down_done one-cycle pulse, down_busy never asserted; WIDTH=4 build with up_max=15 -> wraps 15->0 with pulse.
